// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipelined stage register:
// payload field layout, state encoding and the default bubble word.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int STAGE_W   = 128;
    localparam int FIELD_W   = 32;
    localparam int PC_LSB    = 96;
    localparam int INSTR_LSB = 64;
    localparam int RT_LSB    = 32;
    localparam int C_LSB     = 0;

    localparam logic [STAGE_W-1:0] NOP_WORD = '0;

    // Builds a payload word, MSB first: PC, Instr, rt data, C.
    function automatic logic [STAGE_W-1:0] pack_stage(
        input logic [FIELD_W-1:0] pc,
        input logic [FIELD_W-1:0] instr,
        input logic [FIELD_W-1:0] rt,
        input logic [FIELD_W-1:0] c
    );
        logic [STAGE_W-1:0] w;
        w = NOP_WORD;
        w[PC_LSB    +: FIELD_W] = pc;
        w[INSTR_LSB +: FIELD_W] = instr;
        w[RT_LSB    +: FIELD_W] = rt;
        w[C_LSB     +: FIELD_W] = c;
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with an optional two-entry skid,
// NOP bubbles on empty output and a saturating stall counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W    = STAGE_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_nxt;
    logic [DATA_W-1:0] skid_nxt;
    logic              clear;

    assign clear = reset | flush;

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // In single-register mode a refused word with a new offer just holds,
    // since in_ready is low; only the skid variant can grow to TWO.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_valid && !out_ready) begin
                    state_nxt = (SKID != 0) ? TWO : ONE;
                end else if (!in_valid && out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != EMPTY);
        occupancy = state;
        out_data  = out_valid ? main_q : NOP_VALUE;
        if (SKID != 0) begin
            in_ready = (state != TWO);
        end else begin
            in_ready = out_ready | ~out_valid;
        end
    end

    always_comb begin
        main_nxt = main_q;
        skid_nxt = skid_q;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    main_nxt = in_data;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    main_nxt = in_data;
                end else if (in_valid && (SKID != 0)) begin
                    skid_nxt = in_data;
                end else if (!in_valid && out_ready) begin
                    main_nxt = NOP_VALUE;
                end
            end
            TWO: begin
                if (out_ready) begin
                    main_nxt = skid_q;
                    skid_nxt = NOP_VALUE;
                end
            end
            default: begin
                main_nxt = NOP_VALUE;
                skid_nxt = NOP_VALUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: a skid-mode stage (CNT_W=4) and a single-register
// stage with a non-zero NOP word, checked with immediate assertions.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam logic [31:0] Z_NOP = 32'hDEAD_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    logic [3:0]   stall_cnt;

    logic         z_in_valid;
    logic         z_in_ready;
    logic [31:0]  z_in_data;
    logic         z_out_valid;
    logic         z_out_ready;
    logic [31:0]  z_out_data;
    logic [1:0]   z_occupancy;
    logic [3:0]   z_stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [127:0] wa, wb, wc, wd, we, wf, wg, wh, wi;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (128),
        .SKID   (1),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(
        .DATA_W    (32),
        .NOP_VALUE (Z_NOP),
        .SKID      (0),
        .CNT_W     (4)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .in_data   (z_in_data),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .out_data  (z_out_data),
        .occupancy (z_occupancy),
        .stall_cnt (z_stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wa = pack_stage(32'h0, 32'h0, 32'h0, 32'h3000);
        wb = pack_stage(32'h104, 32'h0001_0113, 32'h5, 32'h7);
        wc = pack_stage(32'h108, 32'h0020_8233, 32'h9, 32'hA);
        wd = pack_stage(32'h10C, 32'h1111_1111, 32'h1, 32'h2);
        we = pack_stage(32'h110, 32'h2222_2222, 32'h3, 32'h4);
        wf = pack_stage(32'h114, 32'h3333_3333, 32'h5, 32'h6);
        wg = pack_stage(32'h118, 32'h4444_4444, 32'h7, 32'h8);
        wh = pack_stage(32'hBAD, 32'hBAD0_BAD0, 32'hBAD, 32'hBAD);
        wi = pack_stage(32'h11C, 32'h5555_5555, 32'h9, 32'hB);

        reset = 1'b1;  flush = 1'b0;
        in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
        z_in_valid = 1'b0;  z_in_data = '0;  z_out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_out_data", out_data, NOP_WORD);
        chk("rst_occupancy", 128'(occupancy), 128'(2'd0));
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(4'd0));

        // First transfer, then stream B and C with out_ready high.
        in_valid = 1'b1;  in_data = wa;  out_ready = 1'b1;
        step();
        chk("first_valid", 128'(out_valid), 128'(1'b1));
        chk("first_data", out_data, wa);
        chk("first_occ", 128'(occupancy), 128'(2'd1));
        in_data = wb;
        step();
        chk("stream_b", out_data, wb);
        chk("stream_b_rdy", 128'(in_ready), 128'(1'b1));
        in_data = wc;
        step();
        chk("stream_c", out_data, wc);
        chk("stream_c_rdy", 128'(in_ready), 128'(1'b1));
        in_valid = 1'b0;
        step();
        chk("drain_valid", 128'(out_valid), 128'(1'b0));
        chk("drain_data", out_data, NOP_WORD);
        chk("drain_occ", 128'(occupancy), 128'(2'd0));

        // Backpressure fills the skid entry.
        out_ready = 1'b0;  in_valid = 1'b1;  in_data = wd;
        step();
        chk("bp1_occ", 128'(occupancy), 128'(2'd1));
        chk("bp1_rdy", 128'(in_ready), 128'(1'b1));
        chk("bp1_data", out_data, wd);
        in_data = we;
        step();
        chk("bp2_occ", 128'(occupancy), 128'(2'd2));
        chk("bp2_rdy", 128'(in_ready), 128'(1'b0));
        chk("bp2_data", out_data, wd);
        chk("bp2_cnt", 128'(stall_cnt), 128'(4'd1));
        in_valid = 1'b0;
        step();
        chk("hold_data", out_data, wd);
        chk("hold_cnt", 128'(stall_cnt), 128'(4'd2));
        out_ready = 1'b1;
        step();
        chk("pop1_data", out_data, we);
        chk("pop1_occ", 128'(occupancy), 128'(2'd1));
        chk("pop1_rdy", 128'(in_ready), 128'(1'b1));
        step();
        chk("pop2_valid", 128'(out_valid), 128'(1'b0));
        chk("pop2_cnt", 128'(stall_cnt), 128'(4'd2));

        // Flush from TWO with a word offered in the same cycle.
        out_ready = 1'b0;  in_valid = 1'b1;  in_data = wf;
        step();
        in_data = wg;
        step();
        chk("pre_flush_occ", 128'(occupancy), 128'(2'd2));
        chk("pre_flush_cnt", 128'(stall_cnt), 128'(4'd3));
        flush = 1'b1;  out_ready = 1'b1;  in_data = wh;
        step();
        flush = 1'b0;  in_valid = 1'b0;
        chk("flush_occ", 128'(occupancy), 128'(2'd0));
        chk("flush_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_data", out_data, NOP_WORD);
        chk("flush_rdy", 128'(in_ready), 128'(1'b1));
        chk("flush_cnt", 128'(stall_cnt), 128'(4'd3));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_flush_valid", 128'(out_valid), 128'(1'b0));
        end

        // Long stall saturates the 4-bit counter.
        out_ready = 1'b0;  in_valid = 1'b1;  in_data = wi;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
        end
        chk("sat_cnt", 128'(stall_cnt), 128'(4'd15));
        chk("sat_data", out_data, wi);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_cnt", 128'(stall_cnt), 128'(4'd0));
        chk("rst2_occ", 128'(occupancy), 128'(2'd0));

        // Single-register mode: combinational in_ready.
        chk("z_rst_data", 128'(z_out_data), 128'(Z_NOP));
        chk("z_rst_rdy", 128'(z_in_ready), 128'(1'b1));
        z_in_valid = 1'b1;  z_in_data = 32'h11;  z_out_ready = 1'b0;
        step();
        chk("z_load_data", 128'(z_out_data), 128'(32'h11));
        chk("z_load_occ", 128'(z_occupancy), 128'(2'd1));
        chk("z_stall_rdy", 128'(z_in_ready), 128'(1'b0));
        z_in_data = 32'h22;
        step();
        chk("z_hold_data", 128'(z_out_data), 128'(32'h11));
        z_out_ready = 1'b1;
        #1;
        chk("z_comb_rdy", 128'(z_in_ready), 128'(1'b1));
        step();
        chk("z_repl_data", 128'(z_out_data), 128'(32'h22));
        chk("z_repl_valid", 128'(z_out_valid), 128'(1'b1));
        z_in_valid = 1'b0;
        step();
        chk("z_empty_valid", 128'(z_out_valid), 128'(1'b0));
        chk("z_empty_data", 128'(z_out_data), 128'(Z_NOP));
        chk("z_cnt", 128'(z_stall_cnt), 128'(4'd1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
